// File: rtl/hyp_req_sched.sv
// hyp_req_sched: round-robin scheduler sharing one hyperbolic CORDIC datapath among NREQ requesters
module hyp_req_sched #(
    parameter int          NREQ    = 4,
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] X_MAX   = 32'h000A_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [2*NREQ-1:0]    req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic [31:0]          dp_x,
    output logic                 dp_en,
    output logic                 dp_abort,
    input  logic [31:0]          dp_epx,
    input  logic [31:0]          dp_sinhx,
    input  logic [31:0]          dp_coshx,
    input  logic                 dp_valid
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t        r_state, w_next;
    logic [2:0]    r_ptr, w_gid;
    logic [1:0]    r_op, w_sop;
    logic [CW-1:0] r_cnt;
    logic [31:0]   w_sx, w_res;
    logic          w_gnt, w_bad, w_acc, w_timeout;
    always_comb begin
        w_gnt = 1'b0;
        w_gid = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_gnt && req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_gnt = 1'b1;
                w_gid = 3'((int'(r_ptr) + k) % NREQ);
            end
        end
        w_sx  = '0;
        w_sop = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (3'(k) == w_gid) begin
                w_sx  = req_x[32*k +: 32];
                w_sop = req_op[2*k +: 2];
            end
        end
    end
    // Signed window [-X_MAX, X_MAX]; op 11 is never valid
    assign w_bad     = (w_sop == 2'b11) || ($signed(w_sx) > $signed(X_MAX)) || ($signed(w_sx) < -$signed(X_MAX));
    assign w_acc     = (r_state == IDLE) && w_gnt;
    assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
    assign w_res     = (r_op == 2'b00) ? dp_epx : (r_op == 2'b01) ? dp_sinhx : dp_coshx;
    assign req_ready = w_acc ? NREQ'(1) << w_gid : '0;
    assign rsp_valid = r_state == RESP;
    assign dp_en     = r_state == ISSUE;
    assign dp_abort  = (r_state == WAIT) && w_timeout && !dp_valid;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_gnt ? (w_bad ? RESP : ISSUE) : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (dp_valid || w_timeout) ? RESP : WAIT;
            default: w_next = rsp_ready ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            dp_x     <= '0;
        end else begin
            if (w_acc) begin
                r_ptr    <= (w_gid == 3'(NREQ - 1)) ? 3'd0 : w_gid + 3'd1;
                r_op     <= w_sop;
                rsp_id   <= w_gid;
                rsp_data <= '0;
                rsp_err  <= w_bad;
                if (!w_bad) dp_x <= w_sx;
            end
            if (r_state == ISSUE) r_cnt <= '0;
            if (r_state == WAIT) begin
                if (dp_valid) begin
                    rsp_data <= w_res;
                    rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_hyp_req_sched.sv
// tb_hyp_req_sched: table-driven directed checks for hyp_req_sched with a delayed-valid datapath model
module tb_hyp_req_sched;
    localparam logic [31:0] EPX  = 32'h0002_B7E1;
    localparam logic [31:0] SINH = 32'h0001_2CD9;
    localparam logic [31:0] COSH = 32'h0001_8B07;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_x = '0;
    logic [7:0]   req_op = '0;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [2:0]   rsp_id;
    logic [31:0]  rsp_data, dp_x;
    logic         dp_en, dp_abort, dp_valid = 1'b0;
    logic [31:0]  dp_epx = EPX, dp_sinhx = SINH, dp_coshx = COSH;
    int           n_chk = 0, n_pass = 0, en_cnt = 0, m_cnt = 0, m_lat = 34;
    logic         m_on = 1'b1;
    logic [31:0]  last_dp_x = '0;
    hyp_req_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
        .req_op(req_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .dp_x(dp_x), .dp_en(dp_en), .dp_abort(dp_abort),
        .dp_epx(dp_epx), .dp_sinhx(dp_sinhx), .dp_coshx(dp_coshx), .dp_valid(dp_valid)
    );
    always #5 clk = ~clk;
    // Datapath model: valid pulse m_lat cycles after dp_en, unless disabled, aborted or reset
    always @(posedge clk) begin
        dp_valid <= 1'b0;
        if (dp_en) begin
            en_cnt    <= en_cnt + 1;
            last_dp_x <= dp_x;
        end
        if (rst || dp_abort) m_cnt <= 0;
        else if (dp_en && m_on) m_cnt <= m_lat;
        else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) dp_valid <= 1'b1;
        end
    end
    typedef struct {
        logic [3:0]  v;
        logic [1:0]  op;
        logic [31:0] x;
        logic [2:0]  id;
        logic        err;
        logic [31:0] data;
    } vec_t;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask
    task automatic drive(input vec_t t);
        logic [127:0] xs;
        logic [7:0]   ops;
        xs  = {4{32'h7FFF_0000}};
        ops = 8'hFF;
        xs[32*t.id +: 32] = t.x;
        ops[2*t.id +: 2]  = t.op;
        req_x     = xs;
        req_op    = ops;
        req_valid = t.v;
    endtask
    task automatic run(input vec_t t);
        int k, en0;
        logic [3:0] oh;
        oh  = 4'b0001 << t.id;
        en0 = en_cnt;
        @(negedge clk);
        drive(t);
        #1 chk("grant", {28'd0, req_ready}, {28'd0, oh});
        @(negedge clk);
        req_valid = '0;
        k = 0;
        while (!rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        if (t.err) chk("ill_latency", k, 0);
        else chk("dp_x", last_dp_x, t.x);
        chk("rsp_id", {29'd0, rsp_id}, {29'd0, t.id});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, t.err});
        chk("rsp_data", rsp_data, t.data);
        chk("dp_en_count", en_cnt - en0, t.err ? 0 : 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
    endtask
    vec_t tbl[13];
    initial begin
        int en_t, ab_t, ab_n, nv, na;
        tbl[0]  = '{4'b0100, 2'b00, 32'h0001_0000, 3'd2, 1'b0, EPX};
        tbl[1]  = '{4'b1111, 2'b01, 32'h0002_0000, 3'd3, 1'b0, SINH};
        tbl[2]  = '{4'b1111, 2'b10, 32'h0000_0000, 3'd0, 1'b0, COSH};
        tbl[3]  = '{4'b1111, 2'b00, 32'hFFFF_0000, 3'd1, 1'b0, EPX};
        tbl[4]  = '{4'b1111, 2'b01, 32'h0000_8000, 3'd2, 1'b0, SINH};
        tbl[5]  = '{4'b1111, 2'b10, 32'h0003_0000, 3'd3, 1'b0, COSH};
        tbl[6]  = '{4'b1111, 2'b00, 32'h0000_4000, 3'd0, 1'b0, EPX};
        tbl[7]  = '{4'b0010, 2'b11, 32'h0000_0000, 3'd1, 1'b1, 32'd0};
        tbl[8]  = '{4'b1000, 2'b00, 32'h000A_0001, 3'd3, 1'b1, 32'd0};
        tbl[9]  = '{4'b1000, 2'b00, 32'hFFF5_FFFF, 3'd3, 1'b1, 32'd0};
        tbl[10] = '{4'b1000, 2'b00, 32'h000A_0000, 3'd3, 1'b0, EPX};
        tbl[11] = '{4'b1001, 2'b10, 32'hFFF6_0000, 3'd0, 1'b0, COSH};
        tbl[12] = '{4'b1001, 2'b01, 32'h0000_0000, 3'd3, 1'b0, SINH};
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_id", {29'd0, rsp_id}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_dp", {dp_x[29:0], dp_en, dp_abort}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 13; i++) run(tbl[i]);
        // Timeout: datapath silent, requester 0 (pointer is 0 here)
        m_on = 1'b0;
        en_t = -1; ab_t = -1; ab_n = 0;
        @(negedge clk);
        drive('{4'b0001, 2'b00, 32'h0000_1000, 3'd0, 1'b0, 32'd0});
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 200 && !rsp_valid; i++) begin
            if (dp_en) en_t = i;
            if (dp_abort) begin ab_t = i; ab_n++; end
            @(negedge clk);
        end
        chk("to_abort_delay", ab_t - en_t, 64);
        chk("to_abort_pulses", ab_n, 1);
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("to_rsp_data", rsp_data, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_on = 1'b1;
        run('{4'b0010, 2'b00, 32'h0000_0000, 3'd1, 1'b0, EPX});
        // Back-pressure: requester 1 keeps requesting while the response is held
        @(negedge clk);
        drive('{4'b0010, 2'b01, 32'h0000_2000, 3'd1, 1'b0, 32'd0});
        for (int i = 0; i < 200 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
            chk("bp_data", rsp_data, SINH);
            chk("bp_id_err", {28'd0, rsp_id, rsp_err}, {28'd0, 3'd1, 1'b0});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_idle_ready", {28'd0, req_ready}, 32'd2);
        req_valid = '0;
        // Reset during WAIT drops the operation silently
        @(negedge clk);
        drive('{4'b0100, 2'b10, 32'h0001_0000, 3'd2, 1'b0, 32'd0});
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_outs", {rsp_valid, rsp_err, dp_en, dp_abort, req_ready, rsp_id}, 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_dp_x", dp_x, 32'd0);
        rst = 1'b0;
        nv = 0; na = 0;
        repeat (80) begin
            @(negedge clk);
            if (rsp_valid) nv++;
            if (dp_abort) na++;
        end
        chk("mid_rst_no_rsp", nv, 0);
        chk("mid_rst_no_abort", na, 0);
        run('{4'b0100, 2'b01, 32'h0000_C000, 3'd2, 1'b0, SINH});
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
